// File: rtl/nubus_master_sched_if.sv
// Bundle between the internal requesters / NuBus pad logic and the master-port scheduler.
// The master modport is the scheduler's view; slave is the requester/pad side.
interface nubus_master_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            done;
  logic            err;
  logic            rqst_o;
  logic            arb_won_i;
  logic            bus_idle_i;
  logic            start_o;
  logic            ack_i;
  logic [1:0]      ack_stat_i;
  logic            master_o;

  modport master (
    input  req, arb_won_i, bus_idle_i, ack_i, ack_stat_i,
    output gnt, done, err, rqst_o, start_o, master_o
  );

  modport slave (
    output req, arb_won_i, bus_idle_i, ack_i, ack_stat_i,
    input  gnt, done, err, rqst_o, start_o, master_o
  );
endinterface

// File: rtl/nubus_master_sched.sv
// Round-robin scheduler sharing the card's NuBus master port between NREQ requesters.
// Optional NUBUS_SCHED_PREREQ_EN: overlap arbitration for the next tenure with the current transfer.
module nubus_master_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int TW      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  nubus_master_sched_if.master bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ARB, START, DATA, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [TW-1:0]   cnt;
  logic            bus_ok;
  logic            keep_rqst;
  int              best_d;

  assign bus_ok = bus.arb_won_i & bus.bus_idle_i;

`ifdef NUBUS_SCHED_PREREQ_EN
  assign keep_rqst = |(bus.req & ~bus.gnt);
`else
  assign keep_rqst = 1'b0;
`endif

  // Winner is the requester at the smallest upward distance from ptr+1.
  always_comb begin
    best_d   = NREQ;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req[PW'(k)] && (((k + NREQ - 1 - int'(ptr)) % NREQ) < best_d)) begin
        best_d   = (k + NREQ - 1 - int'(ptr)) % NREQ;
        pick_idx = PW'(k);
      end
    end
  end

  assign pick_oh = NREQ'(1) << pick_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= PW'(NREQ - 1);
      cnt          <= '0;
      bus.gnt      <= '0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.rqst_o   <= 1'b0;
      bus.start_o  <= 1'b0;
      bus.master_o <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != '0) begin
            bus.gnt    <= pick_oh;
            ptr        <= pick_idx;
            bus.rqst_o <= 1'b1;
            state      <= ARB;
`ifdef NUBUS_SCHED_PREREQ_EN
            // Bus already won during the previous tenure: skip ARB.
            if (bus_ok) begin
              state        <= START;
              bus.start_o  <= 1'b1;
              bus.master_o <= 1'b1;
              bus.rqst_o   <= |(bus.req & ~pick_oh);
            end
`endif
          end else begin
            bus.rqst_o <= 1'b0;
          end
        end
        ARB: begin
          if (bus_ok) begin
            state        <= START;
            bus.start_o  <= 1'b1;
            bus.master_o <= 1'b1;
            bus.rqst_o   <= keep_rqst;
          end
        end
        START: begin
          // cnt tracks cycles elapsed since START.
          cnt        <= TW'(1);
          bus.rqst_o <= keep_rqst;
          state      <= DATA;
        end
        DATA: begin
          cnt        <= cnt + TW'(1);
          bus.rqst_o <= keep_rqst;
          if (bus.ack_i) begin
            bus.done <= 1'b1;
            bus.err  <= (bus.ack_stat_i != 2'b00);
            state    <= DONE;
          end else if (cnt >= TW'(TIMEOUT - 1)) begin
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.gnt      <= '0;
          bus.master_o <= 1'b0;
          bus.rqst_o   <= keep_rqst;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nubus_master_sched.sv
// Directed bench for nubus_master_sched: cycle model of the scheduling rules plus hand-computed checks.
module tb_nubus_master_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 255;
`ifdef NUBUS_SCHED_PREREQ_EN
  localparam bit PREREQ = 1'b1;
`else
  localparam bit PREREQ = 1'b0;
`endif
  localparam int GAP = PREREQ ? 2 : 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mdl_on = 1'b0;

  nubus_master_sched_if #(.NREQ(NREQ)) bus ();

  nubus_master_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [NREQ-1:0] e_gnt;
  logic            e_done, e_err, e_rqst, e_start, e_master;
  logic            m_oth;
  int              m_owner, m_ptr, m_k;

  function automatic int rr_next(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] t;
    for (int i = 1; i <= NREQ; i++) begin
      t = r >> ((p + i) % NREQ);
      if (t[0]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_gnt = '0; e_done = 0; e_err = 0; e_rqst = 0; e_start = 0; e_master = 0;
      m_owner = -1; m_ptr = NREQ - 1; m_k = -1;
    end else begin
      m_oth   = (bus.req & ~e_gnt) != '0;
      e_start = 0;
      if (e_done) begin
        e_done = 0; e_err = 0; e_gnt = '0; e_master = 0; m_owner = -1;
        e_rqst = PREREQ && m_oth;
      end else if (m_owner < 0) begin
        if (bus.req != '0) begin
          m_owner = rr_next(bus.req, m_ptr);
          m_ptr   = m_owner;
          e_gnt   = NREQ'(1) << m_owner;
          e_rqst  = 1;
          m_k     = -1;
          if (PREREQ && bus.arb_won_i && bus.bus_idle_i) begin
            e_start = 1; e_master = 1; m_k = 0;
            e_rqst  = (bus.req & ~e_gnt) != '0;
          end
        end else begin
          e_rqst = 0;
        end
      end else if (m_k < 0) begin
        if (bus.arb_won_i && bus.bus_idle_i) begin
          e_start = 1; e_master = 1; m_k = 0;
          e_rqst  = PREREQ && m_oth;
        end
      end else begin
        // m_k = offset of the ending cycle from START
        e_rqst = PREREQ && m_oth;
        if (m_k >= 1) begin
          if (bus.ack_i) begin
            e_done = 1; e_err = (bus.ack_stat_i != 2'b00);
          end else if (m_k + 1 >= TIMEOUT) begin
            e_done = 1; e_err = 1;
          end
        end
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on)
      chk("outputs_vs_model",
          {bus.gnt, bus.done, bus.err, bus.rqst_o, bus.start_o, bus.master_o},
          {e_gnt, e_done, e_err, e_rqst, e_start, e_master});
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input logic [NREQ-1:0] r, input int ack_at, input logic [1:0] s,
                      input bit drop, output logic [NREQ-1:0] g, output int mcnt,
                      output int st, output int dn, output logic e);
    int dk;
    g = '0; mcnt = 0; st = -1; dn = -1; e = 0; dk = 0;
    bus.req = r;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.ack_i = 0; bus.ack_stat_i = 2'b00;
      if (bus.master_o) mcnt++;
      if (g == '0 && bus.gnt != '0) g = bus.gnt;
      if (drop && bus.gnt != '0) bus.req = '0;
      if (bus.start_o) begin
        st = cyc; dk = 0;
      end else if (st >= 0 && !bus.done) begin
        dk++;
        if (dk == ack_at) begin bus.ack_i = 1; bus.ack_stat_i = s; end
      end
      if (bus.done) begin dn = cyc; e = bus.err; break; end
    end
    chk("xfer_completed", {31'd0, dn >= 0}, 32'd1);
  endtask

  logic [NREQ-1:0] rot_exp [5];
  logic [NREQ-1:0] g;
  int              mc, st, dn, st2, dn2;
  logic            e;

  initial begin
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1; bus.req = '0; bus.arb_won_i = 0; bus.bus_idle_i = 0;
    bus.ack_i = 0; bus.ack_stat_i = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.gnt, bus.done, bus.err, bus.rqst_o, bus.start_o, bus.master_o}, 0);
    mdl_on = 1; reset = 0; bus.arb_won_i = 1; bus.bus_idle_i = 1;

    // round-robin with all requesters held
    for (int i = 0; i < 5; i++) begin
      xfer(4'b1111, 1, 2'b00, 0, g, mc, st, dn, e);
      chk($sformatf("rr_seq_%0d", i), g, rot_exp[i]);
    end

    // pointer to 1, then wrap
    xfer(4'b0010, 1, 2'b00, 0, g, mc, st, dn, e);
    chk("ptr_set", g, 4'b0010);
    xfer(4'b0011, 1, 2'b00, 0, g, mc, st, dn, e);
    chk("wrap_grant", g, 4'b0001);
    xfer(4'b0011, 1, 2'b00, 0, g, mc, st, dn, e);
    chk("wrap_next", g, 4'b0010);

    // basic transfer, ack on 3rd DATA cycle
    xfer(4'b0001, 3, 2'b00, 0, g, mc, st, dn, e);
    chk("basic_gnt", g, 4'b0001);
    chk("basic_master_len", mc, 5);
    chk("basic_start_to_done", dn - st, 4);
    chk("basic_err", {31'd0, e}, 0);

    // bad status
    xfer(4'b0100, 2, 2'b10, 0, g, mc, st, dn, e);
    chk("badstat_gnt", g, 4'b0100);
    chk("badstat_err", {31'd0, e}, 1);

    // timeout, no ack
    xfer(4'b1000, 0, 2'b00, 0, g, mc, st, dn, e);
    chk("timeout_len", dn - st, 255);
    chk("timeout_err", {31'd0, e}, 1);

    // ack coincident with timeout
    xfer(4'b0001, 254, 2'b00, 0, g, mc, st, dn, e);
    chk("coinc_len", dn - st, 255);
    chk("coinc_err", {31'd0, e}, 0);

    // arbitration won but bus busy: must hold in ARB
    bus.bus_idle_i = 0; bus.req = 4'b0010;
    repeat (4) @(negedge clk);
    chk("arb_stall", {bus.rqst_o, bus.start_o, bus.master_o}, 3'b100);
    bus.bus_idle_i = 1;
    xfer(4'b0010, 1, 2'b00, 0, g, mc, st, dn, e);
    chk("arb_stall_gnt", g, 4'b0010);

    // requester drops req after grant
    xfer(4'b0100, 2, 2'b00, 1, g, mc, st, dn, e);
    chk("drop_gnt", g, 4'b0100);

    // asynchronous reset during DATA
    bus.req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.master_o && !bus.start_o) break;
    end
    chk("reach_data", {31'd0, bus.master_o}, 1);
    @(posedge clk); #2 reset = 1;
    #1 chk("reset_async", {bus.gnt, bus.done, bus.err, bus.rqst_o, bus.start_o, bus.master_o}, 0);
    @(negedge clk); bus.req = '0;
    @(negedge clk); reset = 0;
    repeat (5) @(negedge clk);

    // back-to-back tenures with two requesters
    xfer(4'b0011, 1, 2'b00, 0, g, mc, st, dn, e);
    chk("b2b_first", g, 4'b0001);
    chk("b2b_rqst_at_done", {31'd0, bus.rqst_o}, {31'd0, PREREQ});
    xfer(4'b0011, 1, 2'b00, 0, g, mc, st2, dn2, e);
    chk("b2b_second", g, 4'b0010);
    chk("b2b_gap", st2 - dn, GAP);
    bus.req = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end
endmodule
